// File: rtl/tt_mux_select_seq.sv
// Sequencer for the Tiny Tapeout mux control lines: walks the select counter to a
// requested project address (full reset or incremental) and enables it, with a req/done handshake.
module tt_mux_select_seq #(
    parameter int ADDR_W     = 10,
    parameter int MAX_ADDR   = 1023,
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 2,
    parameter int PULSE_CYC  = 2,
    parameter int INCR_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIS,
        S_RST,
        S_REL,
        S_INC_HI,
        S_INC_LO,
        S_ENA
    } state_t;

    localparam int                MAX_W      = ADDR_W + 1;
    localparam logic [ADDR_W:0]   MAX_EXT    = MAX_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] RST_LEN    = ADDR_W'(RST_CYC - 1);
    localparam logic [ADDR_W-1:0] SETTLE_LEN = ADDR_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] PULSE_LEN  = ADDR_W'(PULSE_CYC - 1);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO       = '0;
    localparam bit                INCR       = (INCR_EN != 0);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic [ADDR_W-1:0]   rem_q;
    logic [ADDR_W-1:0]   rem_d;
    logic [ADDR_W-1:0]   tgt_addr;
    logic                tgt_ena;
    logic                accept;
    logic                reject;
    logic                cnt_zero;

    assign cnt_zero = (cnt_q == ZERO);

    // Next-state logic: cnt_q times the current phase, rem_q counts pulses still owed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : (cnt_q - ONE);
        rem_d   = rem_q;
        accept  = 1'b0;
        reject  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (req_valid) begin
                    accept = 1'b1;
                    if ({1'b0, req_addr} > MAX_EXT) begin
                        reject = 1'b1;
                    end else if (cur_valid && (req_addr == cur_addr)) begin
                        state_d = S_ENA;
                    end else begin
                        state_d = S_DIS;
                        cnt_d   = SETTLE_LEN;
                    end
                end
            end
            S_DIS: begin
                if (cnt_zero) begin
                    // Counting up from the known select value avoids a full reset.
                    if (INCR && cur_valid && (tgt_addr > cur_addr)) begin
                        state_d = S_INC_HI;
                        cnt_d   = PULSE_LEN;
                        rem_d   = tgt_addr - cur_addr;
                    end else begin
                        state_d = S_RST;
                        cnt_d   = RST_LEN;
                    end
                end
            end
            S_RST: begin
                if (cnt_zero) begin
                    state_d = S_REL;
                    cnt_d   = SETTLE_LEN;
                    rem_d   = tgt_addr;
                end
            end
            S_REL: begin
                if (cnt_zero) begin
                    if (rem_q == ZERO) begin
                        state_d = S_ENA;
                    end else begin
                        state_d = S_INC_HI;
                        cnt_d   = PULSE_LEN;
                    end
                end
            end
            S_INC_HI: begin
                if (cnt_zero) begin
                    state_d = S_INC_LO;
                    cnt_d   = PULSE_LEN;
                end
            end
            S_INC_LO: begin
                if (cnt_zero) begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = S_ENA;
                    end else begin
                        state_d = S_INC_HI;
                        cnt_d   = PULSE_LEN;
                    end
                end
            end
            S_ENA: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control register stage: outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= ZERO;
            rem_q          <= ZERO;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            cur_addr       <= ZERO;
            cur_valid      <= 1'b0;
            ctrl_sel_rst_n <= 1'b1;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rem_q          <= rem_d;
            req_ready      <= (state_d == S_IDLE);
            busy           <= (state_d != S_IDLE);
            done           <= (state_q == S_ENA);
            err            <= reject;
            ctrl_sel_rst_n <= (state_d != S_RST);
            ctrl_sel_inc   <= (state_d == S_INC_HI);
            if (state_d == S_DIS) begin
                ctrl_ena <= 1'b0;
            end
            if ((state_d == S_RST) && (state_q != S_RST)) begin
                cur_valid <= 1'b0;
            end
            if (state_q == S_ENA) begin
                ctrl_ena  <= tgt_ena;
                cur_addr  <= tgt_addr;
                cur_valid <= 1'b1;
            end
        end
    end

    // Request capture stage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            tgt_addr <= req_addr;
            tgt_ena  <= req_ena;
        end
    end

endmodule

// File: doc/tt_mux_select_seq.md
Name: tt_mux_select_seq

Overview:
Parametrised sequencer that drives the Tiny Tapeout mux control interface (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena) to select and enable a project at a requested address. It replaces hand-toggled select/increment/enable stimulus in benches and firmware-less bring-up with a request/done handshake. It adds an incremental mode that skips the select-counter reset when the target address is above the current one.

Parameters:
ADDR_W, 10, width of project address / select counter
MAX_ADDR, 1023, highest legal address; requests above it are rejected
RST_CYC, 4, cycles ctrl_sel_rst_n is held low (must be >=1)
SETTLE_CYC, 2, cycles for each settle phase (ena-off and post-reset release; must be >=1)
PULSE_CYC, 2, high time and low time of each ctrl_sel_inc pulse (must be >=1)
INCR_EN, 1, 1 = allow incremental selection without counter reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  high in IDLE only
req_addr  input  ADDR_W  target project address
req_ena  input  1  value ctrl_ena takes once selection completes
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a request completes
err  output  1  one-cycle pulse when a request is rejected
cur_addr  output  ADDR_W  address currently selected
cur_valid  output  1  cur_addr is known-good
ctrl_sel_rst_n  output  1  mux select-counter reset, active-low
ctrl_sel_inc  output  1  mux select-counter increment
ctrl_ena  output  1  mux enable

Behaviour:
- One clock and one synchronous active-high reset. All outputs are registered.
- Reset values: ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0, cur_addr=0, cur_valid=0, busy=0, done=0, err=0. The state machine resets to IDLE, so req_ready=1 from the first cycle after reset.
- Reset asserted mid-sequence aborts the sequence and applies the reset values on the next edge. The request is lost and done is not pulsed.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. req_addr and req_ena are latched on that edge.
- Rejection: if the accepted req_addr > MAX_ADDR, err pulses on the next cycle and the block stays in IDLE. No control output and no cur_* value changes.
- Fast path: if cur_valid && req_addr==cur_addr, go straight to ENA. ctrl_ena does not glitch.
- States:
  - IDLE: waits for an accepted request.
  - DIS: ctrl_ena=0 for SETTLE_CYC cycles. Exit to INC_HI when INCR_EN && cur_valid && req_addr>cur_addr, with remaining=req_addr-cur_addr. Otherwise exit to RST.
  - RST: ctrl_sel_rst_n=0 for RST_CYC cycles, then REL. cur_valid clears on entry.
  - REL: ctrl_sel_rst_n=1 for SETTLE_CYC cycles, with remaining=req_addr. Exit to ENA if remaining==0, else INC_HI.
  - INC_HI: ctrl_sel_inc=1 for PULSE_CYC cycles, then INC_LO.
  - INC_LO: ctrl_sel_inc=0 for PULSE_CYC cycles, then remaining decrements. Exit to ENA if the new remaining==0, else INC_HI.
  - ENA: one cycle. On its exit edge: ctrl_ena<=req_ena, cur_addr<=req_addr, cur_valid<=1, done<=1. Then IDLE.
- Pulse and remaining counters are ADDR_W wide and never wrap. A target below cur_addr, or INCR_EN=0, always takes the RST path.
- Latency from the accepting edge to the edge that raises done:
  - Full path: SETTLE_CYC + RST_CYC + SETTLE_CYC + 2*PULSE_CYC*N + 1, where N=req_addr.
  - Incremental path: SETTLE_CYC + 2*PULSE_CYC*N + 1, where N=req_addr-cur_addr.
  - Fast path: 1.
- ctrl_sel_inc and ctrl_sel_rst_n are never low/high simultaneously in a way that changes both on the same edge. ctrl_sel_inc is 0 whenever ctrl_sel_rst_n=0.

Test Plan:
- Reset, then req addr=3 ena=1 with default params -> one rst_n low window of 4 cycles, exactly 3 inc pulses (2 high/2 low), done 21 cycles after acceptance, ctrl_ena=1, cur_addr=3, cur_valid=1.
- After addr 3, req addr=5 ena=1 -> no rst_n low, ctrl_ena low 2 cycles, 2 inc pulses, done after 2+8+1=11 cycles, cur_addr=5.
- After addr 5, req addr=2 -> full reset path, 2 inc pulses, done after 2+4+2+8+1=17 cycles. Repeat with INCR_EN=0 and addr 3 then 5 -> reset path is taken.
- Req addr=5 ena=0 while cur_addr=5 -> done 1 cycle later, ctrl_ena falls without any inc or rst_n activity. Req addr=0 from reset -> rst window, zero inc pulses, done after 9 cycles.
- With MAX_ADDR=7, req addr=8 -> err pulses 1 cycle, no control activity, cur_* unchanged. Assert rst during INC_HI of an addr=6 request -> outputs return to reset values next edge, cur_valid=0, no done pulse.
- Hold req_valid high continuously -> exactly one acceptance per IDLE visit, req_ready=0 and busy=1 throughout each sequence.
